// File: rtl/sid_bus_master.sv
// rtl/sid_bus_master.sv - SID register bus initiator with PHI2-delayed request FIFO
// Optional read path: define SID_BUS_MASTER_READ_EN.
package sid;
  localparam int PHI1 = 0;
  localparam int PHI2 = 1;
  typedef logic [1:0] phase_t;
endpackage

module sid_bus_master #(
  parameter int DEPTH   = 4,
  parameter int DELAY_W = 16
) (
  input  logic                       clk,
  input  logic                       res_n,
  input  sid::phase_t                phase,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [4:0]                 req_addr,
  input  logic [7:0]                 req_data,
  input  logic [DELAY_W-1:0]         req_delay,
  output logic                       rsp_valid,
  output logic [7:0]                 rsp_data,
  output logic                       bus_cs,
  output logic                       bus_we,
  output logic                       bus_oe,
  output logic [4:0]                 bus_addr,
  output logic [7:0]                 bus_data,
  input  logic [7:0]                 bus_rdata,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic               we;
    logic [4:0]         addr;
    logic [7:0]         data;
    logic [DELAY_W-1:0] delay;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, HOLD} state_t;

  req_t               mem [DEPTH];
  req_t               head;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  state_t             state;
  logic               w_we;
  logic [4:0]         w_addr;
  logic [7:0]         w_data;
  logic [DELAY_W-1:0] cnt;
  logic               phi2, push, pop, launch;
  logic               l_we;
  logic [4:0]         l_addr;
  logic [7:0]         l_data;
  logic               unused_inputs;

  assign phi2      = phase[sid::PHI2];
  assign req_ready = (level != LW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (level != '0);
  assign head      = mem[rd_ptr];
  assign busy      = (level != '0) || (state != IDLE);

  // Bus outputs are loaded on the edge that enters ACTIVE, so every PHI2 edge
  // seen in ACTIVE already has stable cs/addr/data across it.
  assign launch = (pop && head.delay == '0) ||
                  (state == WAIT && phi2 && cnt == DELAY_W'(1));
  assign l_we   = (state == IDLE) ? head.we   : w_we;
  assign l_addr = (state == IDLE) ? head.addr : w_addr;
  assign l_data = (state == IDLE) ? head.data : w_data;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{we: req_we, addr: req_addr, data: req_data, delay: req_delay};
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= IDLE;
      cnt      <= '0;
      w_we     <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      bus_cs   <= 1'b0;
      bus_we   <= 1'b0;
      bus_addr <= '0;
      bus_data <= '0;
`ifdef SID_BUS_MASTER_READ_EN
      bus_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`endif
    end else begin
`ifdef SID_BUS_MASTER_READ_EN
      rsp_valid <= 1'b0;
`endif
      if (pop) begin
        w_we   <= head.we;
        w_addr <= head.addr;
        w_data <= head.data;
        cnt    <= head.delay;
      end
      if (launch) begin
`ifdef SID_BUS_MASTER_READ_EN
        state    <= ACTIVE;
        bus_cs   <= 1'b1;
        bus_we   <= l_we;
        bus_oe   <= !l_we;
        bus_addr <= l_addr;
        if (l_we) bus_data <= l_data;
`else
        // Reads still consume their delay but never reach the bus.
        if (l_we) begin
          state    <= ACTIVE;
          bus_cs   <= 1'b1;
          bus_we   <= 1'b1;
          bus_addr <= l_addr;
          bus_data <= l_data;
        end else begin
          state <= IDLE;
        end
`endif
      end else begin
        case (state)
          IDLE:   if (pop) state <= WAIT;
          WAIT:   if (phi2) cnt <= cnt - DELAY_W'(1);
          ACTIVE: if (phi2) state <= HOLD;
          HOLD: begin
            state  <= IDLE;
            bus_cs <= 1'b0;
            bus_we <= 1'b0;
`ifdef SID_BUS_MASTER_READ_EN
            bus_oe <= 1'b0;
            if (!w_we) begin
              rsp_valid <= 1'b1;
              rsp_data  <= bus_rdata;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SID_BUS_MASTER_READ_EN
  assign unused_inputs = phase[sid::PHI1];
`else
  assign bus_oe        = 1'b0;
  assign rsp_valid     = 1'b0;
  assign rsp_data      = '0;
  assign unused_inputs = ^{phase[sid::PHI1], bus_rdata};
`endif

endmodule

// File: tb/tb_sid_bus_master.sv
// tb/tb_sid_bus_master.sv - directed self-checking bench for sid_bus_master
// PHI2 strobes fall on every posedge whose index is a multiple of 8.
module tb_sid_bus_master;
  logic        clk, res_n;
  sid::phase_t phase;
  logic        req_valid, req_ready, req_we;
  logic [4:0]  req_addr;
  logic [7:0]  req_data;
  logic [15:0] req_delay;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        bus_cs, bus_we, bus_oe;
  logic [4:0]  bus_addr;
  logic [7:0]  bus_data;
  logic [7:0]  bus_rdata;
  logic        busy;
  logic [2:0]  level;

  typedef struct { int c; logic we; logic oe; logic [4:0] addr; logic [7:0] data; } smp_t;
  typedef struct { int c; logic [7:0] d; } rsp_t;

  smp_t samples[$];
  rsp_t rsps[$];
  int   rises[$];

  int         cyc = 0;
  int         bad_hold = 0;
  logic       after_sample = 1'b0;
  logic       prev_cs = 1'b0, prev_we = 1'b0, prev_oe = 1'b0;
  logic [4:0] prev_addr = '0;
  logic [7:0] prev_data = '0;
  int         n_tests = 0, n_fail = 0;

`ifdef SID_BUS_MASTER_READ_EN
  localparam logic RST_WE = 1'b0;
`else
  localparam logic RST_WE = 1'b1;
`endif

  sid_bus_master #(.DEPTH(4), .DELAY_W(16)) dut (
    .clk(clk), .res_n(res_n), .phase(phase),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .req_delay(req_delay),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_oe(bus_oe),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_rdata(bus_rdata),
    .busy(busy), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial phase = '0;

  // Bus monitor and phase generator; cyc is the index of the posedge just passed.
  always @(negedge clk) begin
    cyc++;
    if (!res_n) begin
      prev_cs      = 1'b0;
      after_sample = 1'b0;
    end else begin
      if (after_sample) begin
        if (bus_cs) bad_hold++;
        after_sample = 1'b0;
      end
      if (phase[sid::PHI2] && prev_cs) begin
        samples.push_back('{cyc, prev_we, prev_oe, prev_addr, prev_data});
        if (!bus_cs || bus_addr != prev_addr || bus_we != prev_we) bad_hold++;
        after_sample = 1'b1;
      end
      if (bus_cs && !prev_cs) rises.push_back(cyc);
      if (rsp_valid) rsps.push_back('{cyc, rsp_data});
      prev_cs   = bus_cs;
      prev_we   = bus_we;
      prev_oe   = bus_oe;
      prev_addr = bus_addr;
      prev_data = bus_data;
    end
    phase = {((cyc + 1) % 8 == 0), ((cyc + 1) % 8 == 4)};
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int next_strobe(input int c);
    return (c / 8 + 1) * 8;
  endfunction

  task automatic clear_logs();
    samples.delete();
    rsps.delete();
    rises.delete();
  endtask

  task automatic push(input logic we, input logic [4:0] a, input logic [7:0] d,
                      input logic [15:0] dl, output int edge_c);
    int k;
    k = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d; req_delay = dl;
    while (!req_ready && k < 400) begin
      tick();
      k++;
    end
    edge_c = cyc + 1;
    tick();
    req_valid = 1'b0;
    if (k >= 400) check("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 600) begin
      tick();
      k++;
    end
    if (k >= 600) check("idle_timeout", 0, 1);
    tick();
    tick();
  endtask

  initial begin
    int p, p2, s0, acc, k;
    logic [4:0] exp_addr [6];
    exp_addr = '{5'h10, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05};

    res_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_data = '0; req_delay = '0; bus_rdata = 8'hA5;
    tick();
    tick();
    check("rst_ready", req_ready, 1);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_bus", {bus_cs, bus_we, bus_oe, bus_addr, bus_data}, 0);
    check("rst_rsp", {rsp_valid, rsp_data}, 0);
    res_n = 1'b1;
    tick();
    tick();

    // Write, delay 0
    clear_logs();
    push(1'b1, 5'h18, 8'h0F, 16'd0, p);
    wait_idle();
    check("wr0_count", samples.size(), 1);
    check("wr0_addr", samples[0].addr, 5'h18);
    check("wr0_data", samples[0].data, 8'h0F);
    check("wr0_we_oe", {samples[0].we, samples[0].oe}, 2'b10);
    check("wr0_edge", samples[0].c, next_strobe(p + 1));

    // Read, delay 0
    clear_logs();
    push(1'b0, 5'h1B, 8'h00, 16'd0, p);
    wait_idle();
`ifdef SID_BUS_MASTER_READ_EN
    check("rd0_count", samples.size(), 1);
    check("rd0_addr", samples[0].addr, 5'h1B);
    check("rd0_we_oe", {samples[0].we, samples[0].oe}, 2'b01);
    check("rd0_edge", samples[0].c, next_strobe(p + 1));
    check("rd0_rsp_count", rsps.size(), 1);
    check("rd0_rsp_data", rsps[0].d, 8'hA5);
    check("rd0_rsp_edge", rsps[0].c, next_strobe(p + 1) + 1);
`else
    check("rd0_nobus", samples.size() + rises.size(), 0);
    check("rd0_norsp", rsps.size(), 0);
`endif

    // Delay 3: sample on 4th strobe after pop, cs rises on the 3rd
    clear_logs();
    push(1'b1, 5'h05, 8'h33, 16'd3, p);
    wait_idle();
    check("dly3_count", samples.size(), 1);
    check("dly3_addr", samples[0].addr, 5'h05);
    check("dly3_edge", samples[0].c, next_strobe(p + 1) + 24);
    check("dly3_rises", rises.size(), 1);
    check("dly3_rise_edge", rises[0], next_strobe(p + 1) + 16);

    // FIFO full behind a stalled request, then back-to-back drain
    clear_logs();
    push(1'b1, 5'h10, 8'h77, 16'd12, p);
    s0 = next_strobe(p + 1) + 96;
    for (int i = 0; i < 4; i++) push(1'b1, 5'(i + 1), 8'(8'hA1 + i), 16'd0, p2);
    check("full_level", level, 4);
    check("full_ready", req_ready, 0);
    check("full_busy", busy, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h05; req_data = 8'hA5; req_delay = 16'd0;
    k = 0;
    while (!req_ready && k < 400) begin
      tick();
      k++;
    end
    acc = cyc + 1;
    tick();
    req_valid = 1'b0;
    check("full_accept_edge", acc, s0 + 3);
    wait_idle();
    check("full_count", samples.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("full_addr%0d", i), samples[i].addr, exp_addr[i]);
      check($sformatf("full_edge%0d", i), samples[i].c, s0 + 8 * i);
    end

    // Reset in ACTIVE with two requests queued
    clear_logs();
    while ((cyc + 1) % 8 != 1) tick();
    push(RST_WE, 5'h07, 8'h44, 16'd0, p);
    push(1'b1, 5'h08, 8'h45, 16'd0, p2);
    push(1'b1, 5'h09, 8'h46, 16'd0, p2);
    check("rst_pre_cs", bus_cs, 1);
    check("rst_pre_level", level, 2);
    res_n = 1'b0;
    #1;
    check("rst_mid_bus", {bus_cs, bus_we, bus_oe, bus_addr, bus_data}, 0);
    check("rst_mid_level", level, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_busy_rsp", {busy, rsp_valid, rsp_data}, 0);
    tick();
    tick();
    res_n = 1'b1;
    repeat (40) tick();
    check("rst_post_rsp", rsps.size(), 0);
    check("rst_post_bus", samples.size(), 0);
    check("rst_post_level", level, 0);

    // Read at 0x19 followed by a write
    clear_logs();
    push(1'b0, 5'h19, 8'h00, 16'd0, p);
    push(1'b1, 5'h1A, 8'h5C, 16'd0, p2);
    wait_idle();
`ifdef SID_BUS_MASTER_READ_EN
    check("rw_count", samples.size(), 2);
    check("rw_rd_addr", {samples[0].addr, samples[0].oe}, {5'h19, 1'b1});
    check("rw_wr_addr", {samples[1].addr, samples[1].we, samples[1].data}, {5'h1A, 1'b1, 8'h5C});
    check("rw_rsp_count", rsps.size(), 1);
`else
    check("rw_count", samples.size(), 1);
    check("rw_wr_addr", {samples[0].addr, samples[0].we, samples[0].data}, {5'h1A, 1'b1, 8'h5C});
    check("rw_rises", rises.size(), 1);
    check("rw_rsp_count", rsps.size(), 0);
`endif

    check("hold_timing", bad_hold, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
